// File: rtl/rpn_pkg.sv
// ---------------------------------------------------------------------------
// rpn_pkg
// Types and constants shared by the RPN evaluator and its ALU:
//   rpn_state_e : evaluator FSM states
//   OP_*        : 2-bit opcodes carried in tok_data[1:0] of operator tokens
// ---------------------------------------------------------------------------
package rpn_pkg;

  // Sequencing states. IDLE is the only state that takes a token.
  // An operand visits PUSH. An operator visits POP_B, POP_A, EXEC, PUSH_R.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PUSH   = 3'd1,
    POP_B  = 3'd2,
    POP_A  = 3'd3,
    EXEC   = 3'd4,
    PUSH_R = 3'd5
  } rpn_state_e;

  // Opcodes. "a" is second-from-top and "b" is the top of the stack.
  localparam logic [1:0] OP_ADD = 2'b00;  // a + b
  localparam logic [1:0] OP_SUB = 2'b01;  // a - b
  localparam logic [1:0] OP_AND = 2'b10;  // a & b
  localparam logic [1:0] OP_XOR = 2'b11;  // a ^ b

endpackage

// File: rtl/rpn_alu.sv
// ---------------------------------------------------------------------------
// rpn_alu
// Purely combinational operator unit for the RPN evaluator.
// Arithmetic wraps modulo 2^WIDTH. There is no carry or borrow output.
// Ports:
//   a  : second-from-top operand
//   b  : top-of-stack operand
//   op : opcode (OP_ADD / OP_SUB / OP_AND / OP_XOR)
//   r  : result of a op b
// ---------------------------------------------------------------------------
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] r
);

  always_comb begin
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/rpn_eval.sv
// ---------------------------------------------------------------------------
// rpn_eval
// Reverse-Polish evaluator. It acts as the push/pop master of an attached
// lifo with the same WIDTH and DEPTH.
//
// Ports:
//   clk, rst             : clock (rising edge) and asynchronous active-high reset
//   tok_valid/tok_ready  : token handshake. tok_ready is high only in IDLE.
//   tok_is_op, tok_data  : token kind. Operand value, or opcode in [1:0].
//   stk_push, stk_pop    : one-cycle strobes to the lifo. Never both high.
//   stk_data_in          : write data to the lifo
//   stk_data_out         : registered lifo read data (valid the cycle after a pop)
//   stk_empty, stk_full  : lifo flags. Cross-checked against depth_cnt in IDLE.
//   result, result_valid : last operator result. result_valid pulses during PUSH_R.
//   err_underflow        : sticky. Operator issued with fewer than two entries.
//   err_overflow         : sticky. Operand issued with the stack full.
//   err_clr              : synchronous clear of both sticky errors
//   depth_cnt            : shadow occupancy 0..DEPTH (authoritative)
// ---------------------------------------------------------------------------
module rpn_eval
  import rpn_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tok_valid,
  output logic                     tok_ready,
  input  logic                     tok_is_op,
  input  logic [WIDTH-1:0]         tok_data,
  output logic                     stk_push,
  output logic                     stk_pop,
  output logic [WIDTH-1:0]         stk_data_in,
  input  logic [WIDTH-1:0]         stk_data_out,
  input  logic                     stk_empty,
  input  logic                     stk_full,
  output logic [WIDTH-1:0]         result,
  output logic                     result_valid,
  output logic                     err_underflow,
  output logic                     err_overflow,
  input  logic                     err_clr,
  output logic [$clog2(DEPTH):0]   depth_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_TWO  = CW'(2);

  rpn_state_e       state_q,   state_d;
  logic [CW-1:0]    depth_q,   depth_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] b_q,       b_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic [1:0]       opcode_q,  opcode_d;
  logic             err_uf_q,  err_uf_d;
  logic             err_of_q,  err_of_d;

  logic [WIDTH-1:0] alu_r;

  // "a" is read straight off the lifo output during EXEC.
  // "b" was captured one cycle earlier in POP_A.
  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (stk_data_out),
    .b  (b_q),
    .op (opcode_q),
    .r  (alu_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      depth_q   <= '0;
      operand_q <= '0;
      b_q       <= '0;
      result_q  <= '0;
      opcode_q  <= OP_ADD;
      err_uf_q  <= 1'b0;
      err_of_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      depth_q   <= depth_d;
      operand_q <= operand_d;
      b_q       <= b_d;
      result_q  <= result_d;
      opcode_q  <= opcode_d;
      err_uf_q  <= err_uf_d;
      err_of_q  <= err_of_d;
    end
  end

  // Next-state and output logic. err_clr is applied before any new error
  // can be raised, so an error in the same cycle as err_clr leaves the bit set.
  // The depth count changes by +1 on an operand push. For an operator it
  // changes by -1 once, at the result push; the two pops are not tracked
  // individually because the count is only observed in IDLE.
  always_comb begin
    state_d      = state_q;
    depth_d      = depth_q;
    operand_d    = operand_q;
    b_d          = b_q;
    result_d     = result_q;
    opcode_d     = opcode_q;
    err_uf_d     = err_uf_q;
    err_of_d     = err_of_q;
    tok_ready    = 1'b0;
    stk_push     = 1'b0;
    stk_pop      = 1'b0;
    stk_data_in  = '0;
    result_valid = 1'b0;

    if (err_clr) begin
      err_uf_d = 1'b0;
      err_of_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        tok_ready = 1'b1;
        if (tok_valid) begin
          if (tok_is_op) begin
            if (depth_q < DEPTH_TWO) begin
              err_uf_d = 1'b1;
            end else begin
              opcode_d = tok_data[1:0];
              state_d  = POP_B;
            end
          end else begin
            if (depth_q == DEPTH_FULL) begin
              err_of_d = 1'b1;
            end else begin
              operand_d = tok_data;
              state_d   = PUSH;
            end
          end
        end
      end
      PUSH: begin
        stk_push    = 1'b1;
        stk_data_in = operand_q;
        depth_d     = depth_q + CW'(1);
        state_d     = IDLE;
      end
      POP_B: begin
        stk_pop = 1'b1;
        state_d = POP_A;
      end
      POP_A: begin
        stk_pop = 1'b1;
        b_d     = stk_data_out;
        state_d = EXEC;
      end
      EXEC: begin
        result_d = alu_r;
        state_d  = PUSH_R;
      end
      PUSH_R: begin
        stk_push     = 1'b1;
        stk_data_in  = result_q;
        result_valid = 1'b1;
        depth_d      = depth_q - CW'(1);
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // In IDLE the shadow count and the lifo flags must agree.
  // A disagreement means the lifo is not on the same reset or is not
  // sized to match DEPTH.
  flags_consistent: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE) |-> ((stk_full == (depth_q == DEPTH_FULL)) &&
                           (stk_empty == (depth_q == '0))));

  assign result        = result_q;
  assign err_underflow = err_uf_q;
  assign err_overflow  = err_of_q;
  assign depth_cnt     = depth_q;

endmodule

// File: tb/tb_rpn_eval.sv
// Directed bench for rpn_eval with a small behavioural lifo attached.
module tb_rpn_eval;
  import rpn_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tok_valid = 1'b0;
  logic              tok_ready;
  logic              tok_is_op = 1'b0;
  logic [WIDTH-1:0]  tok_data = '0;
  logic              stk_push;
  logic              stk_pop;
  logic [WIDTH-1:0]  stk_data_in;
  logic [WIDTH-1:0]  stk_data_out;
  logic              stk_empty;
  logic              stk_full;
  logic [WIDTH-1:0]  result;
  logic              result_valid;
  logic              err_underflow;
  logic              err_overflow;
  logic              err_clr = 1'b0;
  logic [$clog2(DEPTH):0] depth_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  rpn_eval #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .tok_valid     (tok_valid),
    .tok_ready     (tok_ready),
    .tok_is_op     (tok_is_op),
    .tok_data      (tok_data),
    .stk_push      (stk_push),
    .stk_pop       (stk_pop),
    .stk_data_in   (stk_data_in),
    .stk_data_out  (stk_data_out),
    .stk_empty     (stk_empty),
    .stk_full      (stk_full),
    .result        (result),
    .result_valid  (result_valid),
    .err_underflow (err_underflow),
    .err_overflow  (err_overflow),
    .err_clr       (err_clr),
    .depth_cnt     (depth_cnt)
  );

  // Behavioural lifo sharing the evaluator's reset. data_out is registered
  // on a pop.
  logic [WIDTH-1:0] mem [DEPTH];
  int sp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp           <= 0;
      stk_data_out <= '0;
    end else if (stk_push && sp < DEPTH) begin
      mem[sp] <= stk_data_in;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_data_out <= mem[sp-1];
      sp           <= sp - 1;
    end
  end
  assign stk_empty = (sp == 0);
  assign stk_full  = (sp == DEPTH);

  // Activity monitor, sampled on the falling edge.
  int push_cnt = 0, pop_cnt = 0, rv_cnt = 0;
  int overlap_cnt = 0, ready_bad = 0, dbl_push = 0;
  logic prev_push = 1'b0;
  logic [WIDTH-1:0] res_q[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (stk_push) push_cnt++;
      if (stk_pop) pop_cnt++;
      if (stk_push && stk_pop) overlap_cnt++;
      if (tok_ready && (stk_push || stk_pop || result_valid)) ready_bad++;
      if (stk_push && prev_push) dbl_push++;
      if (result_valid) begin
        rv_cnt++;
        res_q.push_back(result);
      end
      prev_push = stk_push;
    end else begin
      prev_push = 1'b0;
    end
  end

  function automatic logic [WIDTH-1:0] stackTop();
    logic [WIDTH-1:0] v;
    v = '0;
    if (sp > 0) v = mem[sp-1];
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    vec_cnt++;
    assert (observed === expected) else begin
      err_cnt++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents one token at the first IDLE cycle and completes the handshake.
  // keep=1 leaves tok_valid asserted afterwards (back-to-back streaming).
  task automatic applyStimulus(input logic is_op, input logic [WIDTH-1:0] data,
                               input logic keep);
    int n;
    n = 0;
    @(negedge clk);
    while (!tok_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!tok_ready) begin
      vec_cnt++;
      err_cnt++;
      $display("[TB] FAIL handshake_timeout observed=busy expected=ready");
    end
    tok_valid = 1'b1;
    tok_is_op = is_op;
    tok_data  = data;
    @(posedge clk);
    #1;
    if (!keep) tok_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while (!tok_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!tok_ready) begin
      vec_cnt++;
      err_cnt++;
      $display("[TB] FAIL idle_timeout observed=busy expected=idle");
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    tok_valid = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulseErrClr();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  initial begin
    int p0, q0;
    $display("[TB] start");

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_tok_ready", 32'(tok_ready), 32'd1);
    checkOutput("rst_depth", 32'(depth_cnt), 32'd0);
    checkOutput("rst_push_pop", {30'd0, stk_push, stk_pop}, 32'd0);
    checkOutput("rst_data_in", stk_data_in, 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_rv", 32'(result_valid), 32'd0);
    checkOutput("rst_errs", {30'd0, err_underflow, err_overflow}, 32'd0);
    rst = 1'b0;

    // 5 3 ADD with cycle-by-cycle sequencing
    applyStimulus(1'b0, 32'd5, 1'b0);
    checkOutput("op_push_busy", 32'(tok_ready), 32'd0);
    applyStimulus(1'b0, 32'd3, 1'b0);
    waitIdle();
    checkOutput("depth_two", 32'(depth_cnt), 32'd2);
    q0 = rv_cnt;
    applyStimulus(1'b1, 32'(OP_ADD), 1'b0);
    @(negedge clk);
    checkOutput("popb_pop", {30'd0, stk_pop, tok_ready}, 32'd2);
    @(negedge clk);
    checkOutput("popa_pop", {30'd0, stk_pop, stk_push}, 32'd2);
    @(negedge clk);
    checkOutput("exec_idle_bus", {30'd0, stk_pop, stk_push}, 32'd0);
    checkOutput("exec_result_old", result, 32'd0);
    @(negedge clk);
    checkOutput("pushr_strobes", {29'd0, stk_push, result_valid, stk_pop}, 32'd6);
    checkOutput("pushr_data", stk_data_in, 32'd8);
    checkOutput("add_result", result, 32'd8);
    @(negedge clk);
    checkOutput("add_back_idle", {30'd0, tok_ready, result_valid}, 32'd2);
    checkOutput("add_depth", 32'(depth_cnt), 32'd1);
    checkOutput("add_top", stackTop(), 32'd8);
    checkOutput("add_rv_once", 32'(rv_cnt - q0), 32'd1);

    // SUB in both orders, including wraparound
    applyStimulus(1'b0, 32'd10, 1'b0);
    applyStimulus(1'b0, 32'd4, 1'b0);
    applyStimulus(1'b1, 32'(OP_SUB), 1'b0);
    waitIdle();
    checkOutput("sub_10_4", result, 32'd6);
    applyStimulus(1'b0, 32'd4, 1'b0);
    applyStimulus(1'b0, 32'd10, 1'b0);
    applyStimulus(1'b1, 32'(OP_SUB), 1'b0);
    waitIdle();
    checkOutput("sub_4_10", result, 32'hFFFF_FFFA);
    checkOutput("sub_depth", 32'(depth_cnt), 32'd3);

    // Underflow on an empty stack, then with one entry
    doReset();
    p0 = pop_cnt;
    applyStimulus(1'b1, 32'(OP_ADD), 1'b0);
    checkOutput("uf_empty_flag", {30'd0, err_underflow, tok_ready}, 32'd3);
    @(negedge clk);
    checkOutput("uf_empty_nopop", 32'(pop_cnt - p0), 32'd0);
    checkOutput("uf_empty_depth", 32'(depth_cnt), 32'd0);
    pulseErrClr();
    checkOutput("uf_cleared", 32'(err_underflow), 32'd0);
    applyStimulus(1'b0, 32'd9, 1'b0);
    p0 = pop_cnt;
    applyStimulus(1'b1, 32'(OP_ADD), 1'b0);
    checkOutput("uf_one_flag", 32'(err_underflow), 32'd1);
    @(negedge clk);
    checkOutput("uf_one_nopop", 32'(pop_cnt - p0), 32'd0);
    checkOutput("uf_one_depth", 32'(depth_cnt), 32'd1);
    checkOutput("uf_one_top", stackTop(), 32'd9);
    pulseErrClr();

    // Fill to DEPTH, then overflow. Stack holds 9, 1..15.
    for (int i = 1; i <= 15; i++) applyStimulus(1'b0, 32'(i), 1'b0);
    waitIdle();
    checkOutput("full_depth", 32'(depth_cnt), 32'd16);
    checkOutput("full_flag", 32'(stk_full), 32'd1);
    p0 = push_cnt;
    applyStimulus(1'b0, 32'd99, 1'b0);
    checkOutput("of_flag", 32'(err_overflow), 32'd1);
    @(negedge clk);
    checkOutput("of_nopush", 32'(push_cnt - p0), 32'd0);
    checkOutput("of_depth", 32'(depth_cnt), 32'd16);
    checkOutput("of_top", stackTop(), 32'd15);
    // err_clr coinciding with a fresh overflow: the error wins
    pulseErrClr();
    checkOutput("of_cleared", 32'(err_overflow), 32'd0);
    @(negedge clk);
    err_clr = 1'b1;
    tok_valid = 1'b1;
    tok_is_op = 1'b0;
    tok_data = 32'd77;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    tok_valid = 1'b0;
    checkOutput("of_clr_collide", 32'(err_overflow), 32'd1);
    pulseErrClr();
    applyStimulus(1'b1, 32'(OP_XOR), 1'b0);
    waitIdle();
    checkOutput("xor_result", result, 32'd1);
    checkOutput("xor_depth", 32'(depth_cnt), 32'd15);

    // Continuous stream 1 2 3 ADD ADD
    doReset();
    res_q.delete();
    overlap_cnt = 0;
    ready_bad = 0;
    dbl_push = 0;
    applyStimulus(1'b0, 32'd1, 1'b1);
    applyStimulus(1'b0, 32'd2, 1'b1);
    applyStimulus(1'b0, 32'd3, 1'b1);
    applyStimulus(1'b1, 32'(OP_ADD), 1'b1);
    applyStimulus(1'b1, 32'(OP_ADD), 1'b0);
    waitIdle();
    checkOutput("stream_count", 32'(res_q.size()), 32'd2);
    if (res_q.size() == 2) begin
      checkOutput("stream_r0", res_q[0], 32'd5);
      checkOutput("stream_r1", res_q[1], 32'd6);
    end
    checkOutput("stream_overlap", 32'(overlap_cnt), 32'd0);
    checkOutput("stream_ready_busy", 32'(ready_bad), 32'd0);
    checkOutput("stream_dbl_push", 32'(dbl_push), 32'd0);
    checkOutput("stream_depth", 32'(depth_cnt), 32'd1);

    // Reset during POP_A, then 7 7 AND
    applyStimulus(1'b0, 32'd20, 1'b0);
    applyStimulus(1'b0, 32'd30, 1'b0);
    applyStimulus(1'b1, 32'(OP_ADD), 1'b0);
    @(posedge clk);
    #1;
    checkOutput("in_popa", {30'd0, stk_pop, tok_ready}, 32'd2);
    rst = 1'b1;
    #1;
    checkOutput("midrst_strobes", {28'd0, stk_pop, stk_push, result_valid, tok_ready}, 32'd1);
    checkOutput("midrst_depth", 32'(depth_cnt), 32'd0);
    checkOutput("midrst_result", result, 32'd0);
    checkOutput("midrst_data_in", stk_data_in, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 32'd7, 1'b0);
    applyStimulus(1'b0, 32'd7, 1'b0);
    applyStimulus(1'b1, 32'(OP_AND), 1'b0);
    waitIdle();
    checkOutput("and_result", result, 32'd7);
    checkOutput("and_depth", 32'(depth_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
